// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU run controller: run-state encoding as seen
// on the state output, and the CPU data-path width.
package cpu_ctrl_pkg;

    localparam int DW = 32;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl_dbg_scan.sv
// Round-robin scanner of the CPU debug register port. Each address is held
// on debug_addr for SCAN_DIV cycles; on the last of those cycles the read
// data is captured and presented for one cycle on scan_*.
//
// Output protocol: scan_valid is a one-cycle pulse with no back-pressure;
// scan_addr/scan_data are meaningful only in the cycle scan_valid is high
// and hold their value until the next pulse.
module dbg_scan
    import cpu_ctrl_pkg::*;
#(
    parameter int DBG_REGS = 32,
    parameter int SCAN_DIV = 4,
    parameter int AW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] debug_addr,
    input  logic [DW-1:0] debug_data,
    output logic          scan_valid,
    output logic [AW-1:0] scan_addr,
    output logic [DW-1:0] scan_data
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(DBG_REGS - 1);

    logic [DIV_W-1:0] div_q;
    logic             sample;

    assign sample = (div_q == DIV_LAST);

    // Divider, address walk and sample capture advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            debug_addr <= '0;
            scan_valid <= 1'b0;
            scan_addr  <= '0;
            scan_data  <= '0;
        end else begin
            scan_valid <= sample;
            if (sample) begin
                div_q      <= '0;
                scan_addr  <= debug_addr;
                scan_data  <= debug_data;
                debug_addr <= (debug_addr == ADDR_LAST) ? '0 : debug_addr + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller for the pipelined CPU. Produces the CPU
// clock enable, counts enabled cycles, and hosts the debug-port scanner.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DBG_REGS = 32,
    parameter int SCAN_DIV = 4,
    parameter int AW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_req,
    input  logic          step_req,
    input  logic          halt_req,
    input  logic          bp_en,
    input  logic [31:0]   bp_addr,
    input  logic [31:0]   pc,
    input  logic          clr_cnt,
    output logic          cpu_en,
    output logic [1:0]    state,
    output logic [31:0]   cycle_cnt,
    output logic [AW-1:0] debug_addr,
    input  logic [31:0]   debug_data,
    output logic          scan_valid,
    output logic [AW-1:0] scan_addr,
    output logic [31:0]   scan_data
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       skip_q;
    logic       skip_d;
    logic       bp_hit;

    assign state = state_q;

    // skip masks the breakpoint for the first RUN cycle so a resume or a
    // run started on the breakpoint PC executes that instruction once.
    assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;

    // Clock enable: RUN unless stopping on a breakpoint, or the single STEP cycle.
    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            ST_RUN:  cpu_en = !bp_hit;
            ST_STEP: cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    // Next-state selection; halt beats step beats run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (halt_req)
                    state_d = ST_HALT;
                else if (step_req)
                    state_d = ST_STEP;
                else if (run_req)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req)
                    state_d = ST_HALT;
                else if (bp_hit)
                    state_d = ST_BREAK;
            end
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        skip_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    // Run-state register and breakpoint skip flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HALT;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Executed-cycle counter; clear wins over increment, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt)
            cycle_cnt <= '0;
        else if (cpu_en)
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    dbg_scan #(
        .DBG_REGS (DBG_REGS),
        .SCAN_DIV (SCAN_DIV),
        .AW       (AW)
    ) u_dbg_scan (
        .clk        (clk),
        .rst        (rst),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .scan_valid (scan_valid),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomised bench for cpu_run_ctrl with a behavioural reference model and
// queued expectations for control outputs and debug scan samples.
module tb_cpu_run_ctrl;

    localparam int DBG_REGS = 32;
    localparam int SCAN_DIV = 4;
    localparam int AW       = 6;

    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_BREAK = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run_req = 1'b0;
    logic          step_req = 1'b0;
    logic          halt_req = 1'b0;
    logic          bp_en = 1'b0;
    logic [31:0]   bp_addr = 32'd0;
    logic [31:0]   pc = 32'd0;
    logic          clr_cnt = 1'b0;
    logic          cpu_en;
    logic [1:0]    state;
    logic [31:0]   cycle_cnt;
    logic [AW-1:0] debug_addr;
    logic [31:0]   debug_data;
    logic          scan_valid;
    logic [AW-1:0] scan_addr;
    logic [31:0]   scan_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] salt = 32'h0;

    // Expected registered outputs {state, cycle_cnt}, one per cycle.
    logic [33:0]    ctl_q[$];
    // Expected scan samples {addr, data}, one per scan pulse.
    logic [AW+31:0] exp_q[$];

    // Reference model state.
    int          m_mode = M_HALT;
    bit          m_skip = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    int          m_k = 0;
    bit          m_last_en = 1'b0;
    bit          m_ready = 1'b0;

    cpu_run_ctrl #(
        .DBG_REGS (DBG_REGS),
        .SCAN_DIV (SCAN_DIV),
        .AW       (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .clr_cnt    (clr_cnt),
        .cpu_en     (cpu_en),
        .state      (state),
        .cycle_cnt  (cycle_cnt),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .scan_valid (scan_valid),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // CPU debug port stand-in: value is a scrambled function of the address.
    function automatic logic [31:0] resp(input logic [AW-1:0] a);
        return salt ^ (32'(a) * 32'h9E3779B1);
    endfunction

    assign debug_data = resp(debug_addr);

    // Would the CPU advance this cycle given the model's mode and current inputs?
    function automatic bit model_en();
        if (m_mode == M_STEP)
            return 1'b1;
        if (m_mode == M_RUN)
            return !(bp_en && (pc == bp_addr) && !m_skip);
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the run/step/halt/breakpoint rules each edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode    = M_HALT;
                m_skip    = 1'b0;
                m_cnt     = 32'd0;
                m_k       = 0;
                m_last_en = 1'b0;
                m_ready   = 1'b1;
            end else if (m_ready) begin
                automatic bit en = model_en();
                automatic bit hit = (m_mode == M_RUN) && !en;
                automatic bit idle = (m_mode == M_HALT) || (m_mode == M_BREAK);
                automatic int nxt = m_mode;
                m_last_en = en;
                if (clr_cnt)
                    m_cnt = 32'd0;
                else if (en)
                    m_cnt = m_cnt + 32'd1;
                if (halt_req || m_mode == M_STEP)
                    nxt = M_HALT;
                else if (idle && step_req)
                    nxt = M_STEP;
                else if (idle && run_req)
                    nxt = M_RUN;
                else if (hit)
                    nxt = M_BREAK;
                m_skip = (nxt == M_RUN) && (m_mode != M_RUN);
                m_mode = nxt;
                if (m_k % SCAN_DIV == SCAN_DIV - 1) begin
                    automatic logic [AW-1:0] a = AW'((m_k / SCAN_DIV) % DBG_REGS);
                    exp_q.push_back({a, resp(a)});
                end
                m_k++;
            end
            if (m_ready)
                ctl_q.push_back({2'(m_mode), m_cnt});
        end
    end

    // Monitor: samples mid low phase, pops expectations and compares.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (m_ready) begin
                automatic bit exp_valid = (m_k > 0) && (m_k % SCAN_DIV == 0);
                if (ctl_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ctl_q: no expectation queued at %0t", $time);
                end else begin
                    automatic logic [33:0] e = ctl_q.pop_front();
                    chk("state", 32'(state), 32'(e[33:32]));
                    chk("cycle_cnt", cycle_cnt, e[31:0]);
                end
                chk("cpu_en", 32'(cpu_en), 32'(model_en()));
                chk("debug_addr", 32'(debug_addr), 32'((m_k / SCAN_DIV) % DBG_REGS));
                chk("scan_valid", 32'(scan_valid), 32'(exp_valid));
                if (exp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL exp_q: no scan sample queued at %0t", $time);
                    end else begin
                        automatic logic [AW+31:0] s = exp_q.pop_front();
                        if (scan_valid) begin
                            chk("scan_addr", 32'(scan_addr), 32'(s[AW+31:32]));
                            chk("scan_data", scan_data, s[31:0]);
                        end
                    end
                end
            end
        end
    end

    // Driver: one cycle of stimulus, set on the falling edge. pc follows
    // a CPU that advances by one instruction whenever it was enabled.
    task automatic drive(input bit r, input bit s, input bit h, input bit c);
        @(negedge clk);
        if (m_last_en)
            pc = pc + 32'd4;
        run_req  = r;
        step_req = s;
        halt_req = h;
        clr_cnt  = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        idle(n);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        salt = $urandom;
        do_reset(3);

        // Idle after reset: halted, counter zero, scanner running.
        idle(20);
        #3;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt", cycle_cnt, 32'd0);

        // Single step.
        drive(0, 1, 0, 0);
        idle(3);
        #3;
        chk("step_cnt", cycle_cnt, 32'd1);

        // Run into a breakpoint at 0x10 starting from pc 0.
        @(negedge clk);
        pc = 32'd0;
        bp_en = 1'b1;
        bp_addr = 32'h10;
        drive(1, 0, 0, 0);
        idle(8);
        #3;
        chk("bp_state", 32'(state), 32'd3);
        chk("bp_cnt", cycle_cnt, 32'd5);
        chk("bp_pc", pc, 32'h10);

        // Resume past the breakpoint, then halt.
        drive(1, 0, 0, 0);
        idle(5);
        #3;
        chk("resume_state", 32'(state), 32'd1);
        drive(0, 0, 1, 0);
        idle(2);

        // Simultaneous requests in HALT.
        drive(1, 0, 1, 0);
        idle(1);
        #3;
        chk("run_halt_prio", 32'(state), 32'd0);
        drive(1, 1, 0, 0);
        idle(1);
        #3;
        chk("run_step_prio", 32'(state), 32'd2);
        idle(2);

        // Clear during RUN.
        bp_en = 1'b0;
        drive(1, 0, 0, 0);
        idle(4);
        drive(0, 0, 0, 1);
        idle(1);
        #3;
        chk("clr_in_run", cycle_cnt, 32'd0);
        idle(3);

        // Randomised requests, breakpoints near the current pc.
        for (int i = 0; i < 600; i++) begin
            automatic int r = $urandom_range(0, 99);
            if ($urandom_range(0, 29) == 0) begin
                bp_en   = 1'($urandom_range(0, 1));
                bp_addr = pc + 32'($urandom_range(0, 6)) * 32'd4;
            end
            drive(r < 6, (r >= 6) && (r < 10), (r >= 10) && (r < 12),
                  $urandom_range(0, 59) == 0);
        end
        idle(3);

        // Reset in the middle of a run.
        bp_en = 1'b0;
        drive(1, 0, 0, 0);
        idle(6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rst_run_state", 32'(state), 32'd0);
        chk("rst_run_en", 32'(cpu_en), 32'd0);
        chk("rst_run_cnt", cycle_cnt, 32'd0);
        chk("rst_run_dbg", 32'(debug_addr), 32'd0);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
